smart_led_word_decoder_pwm: RTL and testbench

// - Downstream consumer of the 32-bit parity-protected shift-in word of the smart-LED node.
// - Checks the word's parity and use flag, then latches three 10-bit colour channels.
// - Drives three PWM outputs (R,G,B) from one shared 10-bit period counter.
// - Double-buffered: new colour values take effect only at a PWM period boundary (glitch-free).

---
 rtl/smart_led_word_decoder_pwm.sv | 209 ++++++++++++++++++++
 tb/tb_smart_led_word_decoder_pwm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/smart_led_word_decoder_pwm.sv
// smart_led_word_decoder_pwm
// Consumes the 32-bit parity-protected shift-in word of the smart-LED node,
// stages three 10-bit colour channels and drives three PWM outputs from one
// shared, prescaled 10-bit period counter. Staged colours move to the active
// duty registers only at a period boundary, so a period never mixes two duties.
//
// Optional feature: define SMART_LED_ERR_COUNT_EN to add the saturating
// parity-error counter output err_count[7:0].

module smart_led_word_decoder_pwm #(
   parameter int unsigned PRESCALE = 4   // clk cycles per PWM count step, 1..255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        pwm_r,
   output logic        pwm_g,
   output logic        pwm_b,
   output logic        word_accepted,
   output logic        parity_err,
   output logic        period_start
`ifdef SMART_LED_ERR_COUNT_EN
   ,
   output logic [7:0]  err_count
`endif
);

   // Terminal prescaler value; the period counter steps when it is reached.
   localparam logic [7:0] PRESCALE_MAX = 8'(PRESCALE - 1);

   // Even parity over the whole word: good iff the XOR of all bits is zero.
   function automatic logic parity_ok(input logic [31:0] w);
      return ~(^w);
   endfunction

   // Saturating increment used by the error counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [7:0] presc_r;
   logic [9:0] cnt_r;
   logic [9:0] stage_red_r, stage_grn_r, stage_blu_r;
   logic [9:0] act_red_r,   act_grn_r,   act_blu_r;
   logic       pwm_red_r,   pwm_grn_r,   pwm_blu_r;
   logic       accepted_r;
   logic       perr_r;

   // ------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------
   logic       presc_wrap_s;
   logic       period_hit_s;
   logic       word_good_s;
   logic       accept_s;
   logic       reject_s;
   logic [9:0] eff_red_s, eff_grn_s, eff_blu_s;

   // Prescaler wrap and period boundary decode from the current count state.
   always_comb begin
      presc_wrap_s = (presc_r == PRESCALE_MAX);
      period_hit_s = (cnt_r == 10'd0) && (presc_r == 8'd0);
   end

   // Word classification: accepted needs good parity and the use flag set;
   // any bad-parity word is rejected regardless of the use flag.
   always_comb begin
      word_good_s = parity_ok(word_in);
      if (word_valid) begin
         accept_s = word_good_s & word_in[30];
         reject_s = ~word_good_s;
      end else begin
         accept_s = 1'b0;
         reject_s = 1'b0;
      end
   end

   // Duty the counter is compared against: at a period boundary the active
   // registers are about to take the staged value, so compare against that
   // value directly and the whole new period is rendered with the new duty.
   always_comb begin
      if (period_hit_s) begin
         eff_red_s = stage_red_r;
         eff_grn_s = stage_grn_r;
         eff_blu_s = stage_blu_r;
      end else begin
         eff_red_s = act_red_r;
         eff_grn_s = act_grn_r;
         eff_blu_s = act_blu_r;
      end
   end

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------

   // Prescaler and period counter; the 10-bit counter wraps 1023 -> 0 naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= 8'd0;
         cnt_r   <= 10'd0;
      end else if (presc_wrap_s) begin
         presc_r <= 8'd0;
         cnt_r   <= cnt_r + 10'd1;
      end else begin
         presc_r <= presc_r + 8'd1;
         cnt_r   <= cnt_r;
      end
   end

   // Staging registers: written by every accepted word, last one wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_red_r <= 10'd0;
         stage_grn_r <= 10'd0;
         stage_blu_r <= 10'd0;
      end else if (accept_s) begin
         stage_red_r <= word_in[9:0];
         stage_grn_r <= word_in[19:10];
         stage_blu_r <= word_in[29:20];
      end else begin
         stage_red_r <= stage_red_r;
         stage_grn_r <= stage_grn_r;
         stage_blu_r <= stage_blu_r;
      end
   end

   // Active duty load at the period boundary; a word staged in the same
   // cycle is not yet visible here and lands one period later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_red_r <= 10'd0;
         act_grn_r <= 10'd0;
         act_blu_r <= 10'd0;
      end else if (period_hit_s) begin
         act_red_r <= stage_red_r;
         act_grn_r <= stage_grn_r;
         act_blu_r <= stage_blu_r;
      end else begin
         act_red_r <= act_red_r;
         act_grn_r <= act_grn_r;
         act_blu_r <= act_blu_r;
      end
   end

   // Registered PWM compare, one clk behind the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_red_r <= 1'b0;
         pwm_grn_r <= 1'b0;
         pwm_blu_r <= 1'b0;
      end else begin
         pwm_red_r <= (cnt_r < eff_red_s);
         pwm_grn_r <= (cnt_r < eff_grn_s);
         pwm_blu_r <= (cnt_r < eff_blu_s);
      end
   end

   // Status pulses for the cycle after the word strobe; exclusive by construction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accepted_r <= 1'b0;
         perr_r     <= 1'b0;
      end else begin
         accepted_r <= accept_s;
         perr_r     <= reject_s;
      end
   end

`ifdef SMART_LED_ERR_COUNT_EN
   logic [7:0] err_cnt_r;

   // Saturating parity-error count, stepping on the edge that raises parity_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_r <= 8'd0;
      end else if (reject_s) begin
         err_cnt_r <= sat_inc8(err_cnt_r);
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_count = err_cnt_r;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign pwm_r         = pwm_red_r;
   assign pwm_g         = pwm_grn_r;
   assign pwm_b         = pwm_blu_r;
   assign word_accepted = accepted_r;
   assign parity_err    = perr_r;
   // The boundary is a state decode, so it is high in the very first clk after
   // reset release; gating with rst_n keeps it low while reset is held.
   assign period_start  = period_hit_s & rst_n;

endmodule

// File: tb/tb_smart_led_word_decoder_pwm.sv
// Scoreboard bench for smart_led_word_decoder_pwm (PRESCALE = 2).
// Per-cycle expectations for status pulses and period_start, per-period
// expectations for PWM high-time, all produced by a small reference model.

module tb_smart_led_word_decoder_pwm;

   localparam int P = 2;
   localparam int T = 1024 * P;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] word_in = 32'd0;
   logic        word_valid = 1'b0;
   logic        pwm_r, pwm_g, pwm_b;
   logic        word_accepted, parity_err, period_start;
`ifdef SMART_LED_ERR_COUNT_EN
   logic [7:0]  err_count;
`endif

   smart_led_word_decoder_pwm #(.PRESCALE(P)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .word_in       (word_in),
      .word_valid    (word_valid),
      .pwm_r         (pwm_r),
      .pwm_g         (pwm_g),
      .pwm_b         (pwm_b),
      .word_accepted (word_accepted),
      .parity_err    (parity_err),
      .period_start  (period_start)
`ifdef SMART_LED_ERR_COUNT_EN
      ,
      .err_count     (err_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       acc;
      logic       perr;
      logic [7:0] errc;
   } pulse_t;

   typedef struct {
      int r;
      int g;
      int b;
   } duty_t;

   pulse_t pq[$];
   duty_t  dq[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hi_r, hi_g, hi_b;
   int m_sr, m_sg, m_sb;
   int m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk(input int r, input int g, input int b,
                                      input bit u, input bit corrupt);
      logic [30:0] d;
      logic [31:0] w;
      d = {u, 10'(b), 10'(g), 10'(r)};
      w = {^d, d};
      if (corrupt) w[5] = ~w[5];
      return w;
   endfunction

   // One clk: check this cycle's outputs, then drive and predict.
   task automatic step(input logic v, input logic [31:0] w);
      pulse_t e;
      duty_t  d;
      logic   good, acc, perr;
      if (pq.size() > 0) begin
         e = pq.pop_front();
         chk("word_accepted", word_accepted, e.acc);
         chk("parity_err", parity_err, e.perr);
`ifdef SMART_LED_ERR_COUNT_EN
         chk("err_count", err_count, e.errc);
`endif
      end
      chk("period_start", period_start, (cyc % T == 0));
      if (cyc > 0) begin
         hi_r += pwm_r;
         hi_g += pwm_g;
         hi_b += pwm_b;
      end
      if (cyc > 0 && cyc % T == 0) begin
         if (dq.size() == 0) begin
            chk("duty_queue_empty", 1, 0);
         end else begin
            d = dq.pop_front();
            chk("pwm_r_high", hi_r, d.r * P);
            chk("pwm_g_high", hi_g, d.g * P);
            chk("pwm_b_high", hi_b, d.b * P);
         end
         hi_r = 0; hi_g = 0; hi_b = 0;
      end
      if (cyc % T == 0) dq.push_back('{m_sr, m_sg, m_sb});
      word_in    = w;
      word_valid = v;
      good = ((^w) == 1'b0);
      acc  = v && good && w[30];
      perr = v && !good;
      if (acc) begin
         m_sr = int'(w[9:0]);
         m_sg = int'(w[19:10]);
         m_sb = int'(w[29:20]);
      end
      if (perr && m_err < 255) m_err++;
      pq.push_back('{acc, perr, 8'(m_err)});
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step(1'b0, $urandom());
   endtask

   task automatic chk_all_low(input string tag);
      chk({tag, "_pwm_r"}, pwm_r, 0);
      chk({tag, "_pwm_g"}, pwm_g, 0);
      chk({tag, "_pwm_b"}, pwm_b, 0);
      chk({tag, "_acc"}, word_accepted, 0);
      chk({tag, "_perr"}, parity_err, 0);
      chk({tag, "_pstart"}, period_start, 0);
`ifdef SMART_LED_ERR_COUNT_EN
      chk({tag, "_errc"}, err_count, 0);
`endif
   endtask

   // Assert reset (mid-cycle when mid=1), hold, release on a falling edge.
   task automatic do_reset(input bit mid);
      if (mid) begin
         #2;
         rst_n = 1'b0;
         #1;
         chk_all_low("rst_async");
      end
      word_valid = 1'b0;
      @(negedge clk);
      #1;
      chk_all_low("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cyc = 0;
      pq.delete();
      dq.delete();
      hi_r = 0; hi_g = 0; hi_b = 0;
      m_sr = 0; m_sg = 0; m_sb = 0;
      m_err = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      do_reset(1'b0);
      // Period 0 is dark; the 512/0/1023 word applies from period 1.
      run_to(100);
      step(1'b1, mk(512, 0, 1023, 1'b1, 1'b0));
      // Bad parity, then a good word with use=0: neither changes duties.
      run_to(T + 50);
      step(1'b1, mk(512, 0, 1023, 1'b1, 1'b1));
      run_to(T + 60);
      step(1'b1, mk(5, 6, 7, 1'b0, 1'b0));
      // Word staged exactly in the period_start cycle: one period late.
      run_to(3 * T);
      step(1'b1, mk(100, 200, 300, 1'b1, 1'b0));
      // Back-to-back words; last good one wins.
      run_to(4 * T + 20);
      step(1'b1, mk(1, 2, 3, 1'b1, 1'b0));
      step(1'b1, mk(700, 800, 900, 1'b1, 1'b0));
      step(1'b1, mk(9, 9, 9, 1'b1, 1'b1));
      // Mid-period reset while red is high (count 4 < 700).
      run_to(5 * T + 10);
      chk("pre_reset_pwm_r", pwm_r, 1);
      do_reset(1'b1);
      run_to(T + 1);
`ifdef SMART_LED_ERR_COUNT_EN
      for (int i = 0; i < 300; i++) step(1'b1, mk(i % 1024, 3, 4, i[0], 1'b1));
      run_to(cyc + 4);
      chk("err_count_sat", err_count, 255);
`endif
      run_to(2 * T + 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
